morse_encoder: RTL and testbench

Morse transmitter: the counterpart of the decoder's output layer. It accepts a 5-bit letter index (0=A … 25=Z, the same encoding the decoder's argmax emits) over a valid/ready handshake and drives a single-bit key line with standard Morse timing. Timing is dot=1 unit, dash=3 units, intra-letter gap=1 unit and letter gap=3 units. It sits at the stimulus end of the decoder chain and is also used to generate test keying streams.

---
 rtl/morse_encoder.sv | 160 ++++++++++++++++
 tb/tb_morse_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse key-line transmitter: takes a letter index (0=A..25=Z) over valid/ready
// and keys it out as marks and spaces in units of DOT_TICKS clock cycles.
module morse_encoder #(
  parameter int DOT_TICKS = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] letter,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] DOT_M1  = CNT_W'(DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_M1 = CNT_W'(3 * DOT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tick_reg, tick_next;
  logic [1:0]       elem_reg, elem_next;
  logic [1:0]       last_reg, last_next;
  logic [3:0]       pat_reg, pat_next;
  logic             key_out_reg, key_out_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic       rom_ok;
  logic [1:0] rom_last;
  logic [3:0] rom_pat;

  // Pattern is left-aligned: bit 3 is the element sent first, 1 = dash.
  // rom_last is the element count minus one.
  always_comb begin
    rom_ok   = 1'b1;
    rom_last = 2'd0;
    rom_pat  = 4'b0000;
    case (letter)
      5'd0:  begin rom_last = 2'd1; rom_pat = 4'b0100; end // A .-
      5'd1:  begin rom_last = 2'd3; rom_pat = 4'b1000; end // B -...
      5'd2:  begin rom_last = 2'd3; rom_pat = 4'b1010; end // C -.-.
      5'd3:  begin rom_last = 2'd2; rom_pat = 4'b1000; end // D -..
      5'd4:  begin rom_last = 2'd0; rom_pat = 4'b0000; end // E .
      5'd5:  begin rom_last = 2'd3; rom_pat = 4'b0010; end // F ..-.
      5'd6:  begin rom_last = 2'd2; rom_pat = 4'b1100; end // G --.
      5'd7:  begin rom_last = 2'd3; rom_pat = 4'b0000; end // H ....
      5'd8:  begin rom_last = 2'd1; rom_pat = 4'b0000; end // I ..
      5'd9:  begin rom_last = 2'd3; rom_pat = 4'b0111; end // J .---
      5'd10: begin rom_last = 2'd2; rom_pat = 4'b1010; end // K -.-
      5'd11: begin rom_last = 2'd3; rom_pat = 4'b0100; end // L .-..
      5'd12: begin rom_last = 2'd1; rom_pat = 4'b1100; end // M --
      5'd13: begin rom_last = 2'd1; rom_pat = 4'b1000; end // N -.
      5'd14: begin rom_last = 2'd2; rom_pat = 4'b1110; end // O ---
      5'd15: begin rom_last = 2'd3; rom_pat = 4'b0110; end // P .--.
      5'd16: begin rom_last = 2'd3; rom_pat = 4'b1101; end // Q --.-
      5'd17: begin rom_last = 2'd2; rom_pat = 4'b0100; end // R .-.
      5'd18: begin rom_last = 2'd2; rom_pat = 4'b0000; end // S ...
      5'd19: begin rom_last = 2'd0; rom_pat = 4'b1000; end // T -
      5'd20: begin rom_last = 2'd2; rom_pat = 4'b0010; end // U ..-
      5'd21: begin rom_last = 2'd3; rom_pat = 4'b0001; end // V ...-
      5'd22: begin rom_last = 2'd2; rom_pat = 4'b0110; end // W .--
      5'd23: begin rom_last = 2'd3; rom_pat = 4'b1001; end // X -..-
      5'd24: begin rom_last = 2'd3; rom_pat = 4'b1011; end // Y -.--
      5'd25: begin rom_last = 2'd3; rom_pat = 4'b1100; end // Z --..
      default: rom_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    elem_next  = elem_reg;
    last_next  = last_reg;
    pat_next   = pat_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (rom_ok) begin
            state_next = MARK;
            elem_next  = 2'd0;
            last_next  = rom_last;
            pat_next   = rom_pat;
            tick_next  = rom_pat[3] ? DASH_M1 : DOT_M1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      MARK: begin
        if (tick_reg == '0) begin
          if (elem_reg == last_reg) begin
            state_next = LGAP;
            tick_next  = DASH_M1;
          end else begin
            // Shift so bit 3 always holds the element that follows this space.
            state_next = SPACE;
            tick_next  = DOT_M1;
            elem_next  = elem_reg + 2'd1;
            pat_next   = {pat_reg[2:0], 1'b0};
          end
        end else begin
          tick_next = tick_reg - CNT_W'(1);
        end
      end
      SPACE: begin
        if (tick_reg == '0) begin
          state_next = MARK;
          tick_next  = pat_reg[3] ? DASH_M1 : DOT_M1;
        end else begin
          tick_next = tick_reg - CNT_W'(1);
        end
      end
      LGAP: begin
        if (tick_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          tick_next = tick_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    key_out_next = (state_next == MARK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      elem_reg    <= 2'd0;
      last_reg    <= 2'd0;
      pat_reg     <= 4'b0000;
      key_out_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      elem_reg    <= elem_next;
      last_reg    <= last_next;
      pat_reg     <= pat_next;
      key_out_reg <= key_out_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = ~in_ready;
  assign key_out  = key_out_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder: expected keying is built per cycle
// from a dot/dash string table and compared against the DUT every cycle.
module tb_morse_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] letter = 5'd0;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  string morse_tab [26];

  morse_encoder #(.DOT_TICKS(D), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .letter   (letter),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle key level from the cycle after the handshake up to the done cycle.
  task automatic build_wave(input int idx, output bit q[$]);
    string s;
    q = {};
    s = morse_tab[idx];
    for (int e = 0; e < s.len(); e++) begin
      int units;
      units = (s[e] == "-") ? 3 : 1;
      for (int k = 0; k < units * D; k++) q.push_back(1'b1);
      if (e != s.len() - 1)
        for (int k = 0; k < D; k++) q.push_back(1'b0);
    end
    for (int k = 0; k < 3 * D; k++) q.push_back(1'b0);
  endtask

  // Hands a letter over in the current (idle) cycle and follows it to its done cycle.
  // abort_at >= 0 asserts rst at that cycle offset instead of finishing.
  task automatic run_letter(input int idx, input int abort_at, input bit noise);
    bit q[$];
    build_wave(idx, q);
    letter   = 5'(idx);
    in_valid = 1'b1;
    check($sformatf("in_ready_hs[%0d]", idx), int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("abort_key", int'(key_out), 0);
        check("abort_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
          step();
          check("abort_no_done", int'(done), 0);
          check("abort_key_low", int'(key_out), 0);
        end
        $display("[TB] letter %0d aborted by reset at cycle %0d", idx, i + 1);
        return;
      end
      check($sformatf("key[%0d]@%0d", idx, i + 1), int'(key_out), int'(q[i]));
      check($sformatf("busy[%0d]@%0d", idx, i + 1), int'(busy), 1);
      check($sformatf("done_early[%0d]@%0d", idx, i + 1), int'(done), 0);
      check($sformatf("err[%0d]@%0d", idx, i + 1), int'(err), 0);
      if (noise) begin
        in_valid = 1'($urandom);
        letter   = 5'($urandom);
      end
      step();
    end
    in_valid = 1'b0;
    check($sformatf("done[%0d]", idx), int'(done), 1);
    check($sformatf("ready_end[%0d]", idx), int'(in_ready), 1);
    check($sformatf("key_end[%0d]", idx), int'(key_out), 0);
    $display("[TB] letter %0d (%s) keyed, done after %0d cycles", idx, morse_tab[idx], q.size() + 1);
  endtask

  task automatic send_invalid(input int idx);
    letter   = 5'(idx);
    in_valid = 1'b1;
    check("inv_ready_hs", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("inv_err", int'(err), 1);
    check("inv_key", int'(key_out), 0);
    check("inv_ready", int'(in_ready), 1);
    check("inv_done", int'(done), 0);
    step();
    check("inv_err_clear", int'(err), 0);
    check("inv_key_low", int'(key_out), 0);
    $display("[TB] invalid index %0d consumed", idx);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check("idle_key", int'(key_out), 0);
      check("idle_ready", int'(in_ready), 1);
      check("idle_done", int'(done), 0);
      check("idle_err", int'(err), 0);
    end
  endtask

  initial begin
    morse_tab = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                  ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                  "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    rst = 1'b1;
    step();
    step();
    check("rst_key", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    idle(2);

    run_letter(4, -1, 1'b0);    // E
    idle(3);
    run_letter(0, -1, 1'b0);    // A
    idle(2);
    run_letter(24, -1, 1'b0);   // Y, then T accepted on the done cycle
    run_letter(19, -1, 1'b0);
    idle(2);
    send_invalid(26);
    run_letter(4, -1, 1'b0);
    idle(1);
    send_invalid(26 + int'($urandom_range(0, 5)));
    idle(1);
    run_letter(16, 18, 1'b0);   // Q, reset inside its second dash
    idle(2);
    run_letter(16, -1, 1'b1);
    idle(1);

    for (int l = 0; l < 26; l++) begin
      run_letter(l, -1, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 7) == 0) send_invalid(26 + int'($urandom_range(0, 5)));
      else run_letter(int'($urandom_range(0, 25)), -1, 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
